reg_share_arbiter: RTL and testbench

//  Round-robin arbiter and write sequencer for one shared W-bit register (q).
//  N requesters compete for write access. Each requester presents req and wdata.
//  A winner gets a grant, and its data is written to q while it holds the grant.
//  A winner may lock the register for a bounded write burst.

---
 rtl/reg_arb_pkg.sv | 20 ++
 rtl/reg_share_arbiter_rr_pick.sv | 31 +++
 rtl/reg_share_arbiter.sv | 157 +++++++++++++++
 tb/tb_reg_share_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the shared-register arbiter.
//   arb_state_t : arbiter FSM state encoding
//   oh_to_idx   : one-hot vector (up to 32 bits) to bit index
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Returns the index of the set bit; zero when no bit is set.
  function automatic int unsigned oh_to_idx(input logic [31:0] oh);
    oh_to_idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) oh_to_idx = i;
    end
  endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : per-requester request vector
//   ptr    : index of the last served requester; the search starts at ptr+1
//   winner : one-hot winner (all-zero when no request)
//   valid  : at least one request present
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   winner,
  output logic           valid
);

  logic [IDW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter and write sequencer for one shared W-bit register.
// Optional build macro: REG_ARB_PRIO_EN gives requester 0 absolute priority
// in IDLE; its grants leave the rr pointer untouched.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req, lock : per-requester request / burst-lock request
//   wdata     : packed write data, lane i = wdata[i*W +: W]
//   gnt       : one-hot grant
//   q         : shared register, q_owner : last writer index
//   busy      : FSM in GRANT or LOCKED
//   lock_err  : one-cycle pulse after a burst is forcibly released
//
// state  | meaning
// IDLE   | no grant; arbitrate pending requests
// GRANT  | single grant cycle; write if owner requests, maybe enter burst
// LOCKED | burst in progress; owner keeps grant until release or MAX_LOCK
module reg_share_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_LOCK = 16,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic [IDW-1:0] q_owner,
  output logic           busy,
  output logic           lock_err
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [N-1:0]   gnt_nxt;
  logic [W-1:0]   q_nxt;
  logic [IDW-1:0] owner_nxt;
  logic           lock_err_nxt;

  logic [N-1:0]   rr_win, pick;
  logic           pick_valid;
  logic [IDW-1:0] cur_i;
  logic [W-1:0]   lane;
  logic           req_g, lock_g;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (rr_win),
    .valid  (pick_valid)
  );

`ifdef REG_ARB_PRIO_EN
  assign pick = req[0] ? {{(N-1){1'b0}}, 1'b1} : rr_win;
`else
  assign pick = rr_win;
`endif

  // Only the granted requester's req/lock/data matter; everything else is ignored.
  assign cur_i  = IDW'(oh_to_idx(32'(gnt)));
  assign req_g  = |(req & gnt);
  assign lock_g = |(lock & gnt);
  assign busy   = (state != IDLE);

  always_comb begin
    lane = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) lane = wdata[i*W +: W];
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    q_nxt        = q;
    owner_nxt    = q_owner;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    lock_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_nxt   = pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (req_g) begin
          q_nxt     = lane;
          owner_nxt = cur_i;
        end
`ifdef REG_ARB_PRIO_EN
        if (cur_i != '0) ptr_nxt = cur_i;
`else
        ptr_nxt = cur_i;
`endif
        if (req_g && lock_g) begin
          state_nxt = LOCKED;
          cnt_nxt   = CW'(1);
        end else begin
          gnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      LOCKED: begin
        if (req_g) begin
          q_nxt     = lane;
          owner_nxt = cur_i;
          cnt_nxt   = cnt + CW'(1);
        end
        if (!(req_g && lock_g)) begin
          gnt_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == CW'(MAX_LOCK)) begin
          gnt_nxt      = '0;
          cnt_nxt      = '0;
          lock_err_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      q        <= '0;
      q_owner  <= '0;
      ptr      <= IDW'(N - 1);
      cnt      <= '0;
      lock_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      q        <= q_nxt;
      q_owner  <= owner_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      lock_err <= lock_err_nxt;
    end
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter (N=4, W=8, MAX_LOCK=16).
// With REG_ARB_PRIO_EN defined it runs the priority scenario instead of the
// pure round-robin scenarios.
module tb_reg_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  q_owner;
  logic        busy;
  logic        lock_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_share_arbiter #(.N(4), .W(8), .MAX_LOCK(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .lock     (lock),
    .wdata    (wdata),
    .gnt      (gnt),
    .q        (q),
    .q_owner  (q_owner),
    .busy     (busy),
    .lock_err (lock_err)
  );

  localparam logic [3:0] T2_GNT [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                                        4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
  localparam logic [7:0] T2_Q   [9] = '{8'h00, 8'h10, 8'h10, 8'h11,
                                        8'h11, 8'h12, 8'h12, 8'h13, 8'h13};
  localparam logic [1:0] T2_OWN [9] = '{2'd0, 2'd0, 2'd0, 2'd1,
                                        2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; lock = '0; wdata = '0;
    tick(); tick();
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    checks++;
    if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", q); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (q_owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", q_owner); end
    checks++;
    if (lock_err !== 1'b0) begin errors++; $display("FAIL reset_lock_err got %b want 0", lock_err); end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    req   = 4'b1111;
    lock  = 4'b0000;
    for (int n = 0; n < 9; n++) begin
      tick();
      checks++;
      if (gnt !== T2_GNT[n]) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", n, gnt, T2_GNT[n]); end
      checks++;
      if (q !== T2_Q[n]) begin errors++; $display("FAIL rr_q[%0d] got %h want %h", n, q, T2_Q[n]); end
      checks++;
      if (q_owner !== T2_OWN[n]) begin errors++; $display("FAIL rr_owner[%0d] got %0d want %0d", n, q_owner, T2_OWN[n]); end
      checks++;
      if (busy !== (T2_GNT[n] != 4'b0000)) begin errors++; $display("FAIL rr_busy[%0d] got %b", n, busy); end
    end
    // Grant to requester 0 is live but its request drops: no write.
    req = '0;
    tick();
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_drop_gnt got %b want 0000", gnt); end
    checks++;
    if (q !== 8'h13 || q_owner !== 2'd3) begin
      errors++; $display("FAIL rr_drop_hold got q=%h owner=%0d want q=13 owner=3", q, q_owner);
    end
  endtask

  task automatic test_lock_burst();
    req   = 4'b0101;
    lock  = 4'b0100;
    wdata = {8'h00, 8'hA5, 8'h00, 8'hEE};
    tick();
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL lk_first_gnt got %b want 0100", gnt); end
    tick();
    checks++;
    if (q !== 8'hA5 || q_owner !== 2'd2) begin
      errors++; $display("FAIL lk_write1 got q=%h owner=%0d want q=a5 owner=2", q, q_owner);
    end
    wdata[16 +: 8] = 8'h5A;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || q !== 8'h5A || lock_err !== 1'b0) begin
        errors++; $display("FAIL lk_hold[%0d] got gnt=%b q=%h lock_err=%b want 0100/5a/0", n, gnt, q, lock_err);
      end
    end
    lock = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL lk_release got gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    checks++;
    if (q !== 8'h5A || q_owner !== 2'd2 || lock_err !== 1'b0) begin
      errors++; $display("FAIL lk_final got q=%h owner=%0d lock_err=%b want 5a/2/0", q, q_owner, lock_err);
    end
    // Requester 0 was pending throughout and is served next.
    tick();
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL lk_pending_gnt got %b want 0001", gnt); end
    req = '0;
    tick();
    checks++;
    if (q !== 8'h5A || gnt !== 4'b0000) begin
      errors++; $display("FAIL lk_no_write got q=%h gnt=%b want 5a/0000", q, gnt);
    end
  endtask

  task automatic test_max_lock();
    req   = 4'b1010;
    lock  = 4'b0010;
    wdata = {8'hC3, 8'h00, 8'h00, 8'h00};
    for (int n = 1; n <= 18; n++) begin
      wdata[8 +: 8] = 8'(n);
      tick();
      checks++;
      if (gnt !== ((n < 18) ? 4'b0010 : 4'b0000)) begin
        errors++; $display("FAIL ml_gnt[%0d] got %b", n, gnt);
      end
      checks++;
      if (lock_err !== (n == 18)) begin
        errors++; $display("FAIL ml_lock_err[%0d] got %b want %b", n, lock_err, (n == 18));
      end
      if (n >= 2) begin
        checks++;
        if (q !== 8'(n) || q_owner !== 2'd1) begin
          errors++; $display("FAIL ml_q[%0d] got q=%h owner=%0d want q=%h owner=1", n, q, q_owner, 8'(n));
        end
      end
    end
    tick();
    checks++;
    if (gnt !== 4'b1000 || lock_err !== 1'b0) begin
      errors++; $display("FAIL ml_next_gnt got gnt=%b lock_err=%b want 1000/0", gnt, lock_err);
    end
    tick();
    checks++;
    if (q !== 8'hC3 || q_owner !== 2'd3) begin
      errors++; $display("FAIL ml_req3_write got q=%h owner=%0d want c3/3", q, q_owner);
    end
    tick();
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL ml_regrant got %b want 0010", gnt); end
  endtask

  task automatic test_reset_mid_lock();
    tick();
    checks++;
    if (gnt !== 4'b0010 || busy !== 1'b1 || q !== 8'd18) begin
      errors++; $display("FAIL rl_locked got gnt=%b busy=%b q=%h want 0010/1/12", gnt, busy, q);
    end
    wdata[8 +: 8] = 8'h77;
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'h00 || q_owner !== 2'd0 || lock_err !== 1'b0) begin
      errors++; $display("FAIL rl_abort got gnt=%b busy=%b q=%h owner=%0d lock_err=%b want all 0",
                         gnt, busy, q, q_owner, lock_err);
    end
    req  = '0;
    lock = 4'b1111;
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (gnt !== 4'b0000 || q !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL rl_lock_no_req got gnt=%b q=%h busy=%b want 0000/00/0", gnt, q, busy);
    end
    lock = '0;
  endtask

  task automatic test_prio();
    req   = 4'b1001;
    lock  = 4'b0000;
    wdata = {8'h03, 8'h00, 8'h00, 8'h01};
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if (gnt !== ((n % 2 == 0) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL pr_gnt[%0d] got %b", n, gnt);
      end
      if (n % 2 == 1) begin
        checks++;
        if (q !== 8'h01 || q_owner !== 2'd0) begin
          errors++; $display("FAIL pr_q[%0d] got q=%h owner=%0d want 01/0", n, q, q_owner);
        end
      end
    end
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL pr_req3_gnt got %b want 1000", gnt); end
    tick();
    checks++;
    if (q !== 8'h03 || q_owner !== 2'd3 || gnt !== 4'b0000) begin
      errors++; $display("FAIL pr_req3_write got q=%h owner=%0d gnt=%b want 03/3/0000", q, q_owner, gnt);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
`ifdef REG_ARB_PRIO_EN
    test_prio();
`else
    test_round_robin();
    test_lock_burst();
    test_max_lock();
    test_reset_mid_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
